// File: rtl/floo_sched_pkg.sv
// Shared types and default timing constants for the cluster run controller.
package floo_sched_pkg;

  typedef enum logic [2:0] {
    SchedIdle,
    SchedRelease,
    SchedRun,
    SchedDrain,
    SchedDone,
    SchedTimeout
  } sched_state_e;

  localparam int unsigned DefaultStaggerCycles = 4;
  localparam int unsigned DefaultDrainCycles   = 100;

endpackage

// File: rtl/floo_sched_find_next.sv
// Finds the lowest set bit of en_i strictly above ptr_i (or from bit 0 when first_i).
module floo_sched_find_next #(
  parameter int unsigned NumBits = 32,
  parameter int unsigned PtrW    = 5
) (
  input  logic [NumBits-1:0] en_i,
  input  logic [PtrW-1:0]    ptr_i,
  input  logic               first_i,
  output logic [PtrW-1:0]    idx_o,
  output logic               valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < NumBits; i++) begin
      if (!valid_o && en_i[i] && (first_i || (i > 32'(ptr_i)))) begin
        idx_o   = PtrW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/floo_cluster_sched.sv
// Staggered cluster release, sticky completion capture, timeout and drain sequencing.
module floo_cluster_sched
  import floo_sched_pkg::*;
#(
  parameter int unsigned NumClusters   = 32,
  parameter int unsigned StaggerCycles = DefaultStaggerCycles,
  parameter int unsigned DrainCycles   = DefaultDrainCycles,
  parameter int unsigned CntWidth      = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_i,
  input  logic                             clear_i,
  input  logic [NumClusters-1:0]           enable_i,
  input  logic [CntWidth-1:0]              timeout_i,
  input  logic [NumClusters-1:0]           eoc_i,
  output logic [NumClusters-1:0]           fetch_en_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             timeout_o,
  output logic [NumClusters-1:0]           done_mask_o,
  output logic [$clog2(NumClusters+1)-1:0] num_done_o,
  output logic [CntWidth-1:0]              cycles_o
);

  localparam int unsigned PtrW = (NumClusters > 1) ? $clog2(NumClusters) : 1;
  localparam int unsigned NdW  = $clog2(NumClusters + 1);

  sched_state_e           state_q;
  logic [NumClusters-1:0] en_q, fetch_en_q, done_mask_q;
  logic [PtrW-1:0]        ptr_q;
  logic [CntWidth-1:0]    scnt_q, dcnt_q, cycles_q;
  logic [NdW-1:0]         num_done_q;
  logic                   busy_q, done_q, timeout_q;

  logic [PtrW-1:0]        next_idx, first_idx;
  logic                   next_valid, first_valid;
  logic [NumClusters-1:0] mask_next;
  logic [NdW-1:0]         pop_next;
  logic [CntWidth-1:0]    cycles_inc;
  logic                   timeout_hit, mask_full, next_full;

  floo_sched_find_next #(.NumBits(NumClusters), .PtrW(PtrW)) i_find_next (
    .en_i(en_q), .ptr_i(ptr_q), .first_i(1'b0), .idx_o(next_idx), .valid_o(next_valid)
  );

  floo_sched_find_next #(.NumBits(NumClusters), .PtrW(PtrW)) i_find_first (
    .en_i(enable_i), .ptr_i('0), .first_i(1'b1), .idx_o(first_idx), .valid_o(first_valid)
  );

  always_comb begin
    mask_next   = done_mask_q | (eoc_i & fetch_en_q & en_q);
    mask_full   = (done_mask_q & en_q) == en_q;
    next_full   = (mask_next & en_q) == en_q;
    timeout_hit = (timeout_i != '0) && (cycles_q == timeout_i - CntWidth'(1));
    cycles_inc  = (cycles_q == '1) ? cycles_q : cycles_q + CntWidth'(1);
    pop_next    = '0;
    for (int unsigned i = 0; i < NumClusters; i++) begin
      pop_next = pop_next + NdW'(mask_next[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= SchedIdle;
      en_q        <= '0;
      fetch_en_q  <= '0;
      done_mask_q <= '0;
      num_done_q  <= '0;
      ptr_q       <= '0;
      scnt_q      <= '0;
      dcnt_q      <= '0;
      cycles_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        SchedIdle: begin
          if (start_i) begin
            en_q        <= enable_i;
            fetch_en_q  <= '0;
            done_mask_q <= '0;
            num_done_q  <= '0;
            cycles_q    <= '0;
            busy_q      <= 1'b1;
            if (!first_valid) begin
              state_q <= SchedDrain;
              dcnt_q  <= '0;
            end else begin
              state_q <= SchedRelease;
              ptr_q   <= first_idx;
              scnt_q  <= '0;
            end
          end
        end
        SchedRelease: begin
          cycles_q    <= cycles_inc;
          done_mask_q <= mask_next;
          num_done_q  <= pop_next;
          if (timeout_hit) begin
            state_q   <= SchedTimeout;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else if (scnt_q == '0) begin
            fetch_en_q[ptr_q] <= 1'b1;
            if (next_valid) begin
              ptr_q  <= next_idx;
              scnt_q <= CntWidth'(StaggerCycles - 1);
            end else begin
              state_q <= SchedRun;
            end
          end else begin
            scnt_q <= scnt_q - CntWidth'(1);
          end
        end
        SchedRun: begin
          cycles_q    <= cycles_inc;
          done_mask_q <= mask_next;
          num_done_q  <= pop_next;
          // Drain length is preloaded so DONE always lands DrainCycles+1 edges
          // after the last capture, whether or not it raced the timeout.
          if (mask_full) begin
            state_q <= SchedDrain;
            dcnt_q  <= CntWidth'(1);
          end else if (timeout_hit) begin
            if (next_full) begin
              state_q <= SchedDrain;
              dcnt_q  <= '0;
            end else begin
              state_q   <= SchedTimeout;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              timeout_q <= 1'b1;
            end
          end
        end
        SchedDrain: begin
          cycles_q <= cycles_inc;
          if (dcnt_q == CntWidth'(DrainCycles)) begin
            state_q <= SchedDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            dcnt_q <= dcnt_q + CntWidth'(1);
          end
        end
        SchedDone, SchedTimeout: begin
          if (clear_i) begin
            state_q     <= SchedIdle;
            fetch_en_q  <= '0;
            done_mask_q <= '0;
            num_done_q  <= '0;
            cycles_q    <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
          end
        end
        default: state_q <= SchedIdle;
      endcase
    end
  end

  assign fetch_en_o  = fetch_en_q;
  assign done_mask_o = done_mask_q;
  assign num_done_o  = num_done_q;
  assign cycles_o    = cycles_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_floo_cluster_sched.sv
// Randomized bench for floo_cluster_sched against an event-time reference model.
module tb_floo_cluster_sched;

  localparam int unsigned N = 4;
  localparam int unsigned S = 4;
  localparam int unsigned D = 12;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_ni, start_i, clear_i;
  logic [N-1:0] enable_i, eoc_i, fetch_en_o, done_mask_o;
  logic [W-1:0] timeout_i, cycles_o;
  logic         busy_o, done_o, timeout_o;
  logic [2:0]   num_done_o;

  int checks   = 0;
  int failures = 0;
  int eoc_on [N];

  floo_cluster_sched #(
    .NumClusters(N), .StaggerCycles(S), .DrainCycles(D), .CntWidth(W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .clear_i(clear_i),
    .enable_i(enable_i), .timeout_i(timeout_i), .eoc_i(eoc_i),
    .fetch_en_o(fetch_en_o), .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
    .done_mask_o(done_mask_o), .num_done_o(num_done_o), .cycles_o(cycles_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".fetch_en"}, 32'(fetch_en_o), 0);
    chk({tag, ".done_mask"}, 32'(done_mask_o), 0);
    chk({tag, ".num_done"}, 32'(num_done_o), 0);
    chk({tag, ".cycles"}, cycles_o, 0);
    chk({tag, ".busy"}, 32'(busy_o), 0);
    chk({tag, ".done"}, 32'(done_o), 0);
    chk({tag, ".timeout"}, 32'(timeout_o), 0);
  endtask

  // Edge 0 samples start; model derives release, capture and finish edges from the rules.
  task automatic run_case(input logic [N-1:0] en, input int unsigned tmo, input int abort_at);
    int rel [N];
    int cap [N];
    int k, last, done_edge, m, t;
    bit is_to;
    logic [N-1:0] xf, xm;
    k = 0;
    last = 0;
    t = int'(tmo);
    for (int i = 0; i < N; i++) begin
      rel[i] = -1;
      cap[i] = -1;
      if (en[i]) begin
        rel[i] = 1 + k * S;
        k++;
        cap[i] = (eoc_on[i] > rel[i] + 1) ? eoc_on[i] : rel[i] + 1;
        if (cap[i] > last) last = cap[i];
      end
    end
    is_to = (en != '0) && (tmo != 0) && (last > t);
    done_edge = is_to ? t : last + 1 + D;
    for (int n = 0; n <= done_edge + 3; n++) begin
      if (abort_at >= 0 && n > abort_at) return;
      start_i   = (n == 0) || (n > done_edge);
      enable_i  = (n == 0) ? en : N'($urandom);
      timeout_i = tmo;
      for (int i = 0; i < N; i++) eoc_i[i] = (n >= eoc_on[i]);
      step();
      m = (n < done_edge) ? n : done_edge;
      xf = '0;
      xm = '0;
      for (int i = 0; i < N; i++) begin
        if (en[i] && rel[i] <= m && (!is_to || rel[i] < t)) xf[i] = 1'b1;
        if (en[i] && cap[i] <= m && (!is_to || cap[i] <= t)) xm[i] = 1'b1;
      end
      chk("fetch_en", 32'(fetch_en_o), 32'(xf));
      chk("done_mask", 32'(done_mask_o), 32'(xm));
      chk("num_done", 32'(num_done_o), 32'($countones(xm)));
      chk("busy", 32'(busy_o), 32'(n < done_edge));
      chk("done", 32'(done_o), 32'(n >= done_edge));
      chk("timeout", 32'(timeout_o), 32'(is_to && n >= done_edge));
      chk("cycles", cycles_o, 32'(m));
    end
    start_i = 1'b0;
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    check_idle("clear");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; clear_i = 1'b0;
    enable_i = '0; eoc_i = '0; timeout_i = '0;
    step();
    step();
    check_idle("reset");
    rst_ni = 1'b1;
    eoc_i = '1;
    step();
    check_idle("idle_eoc");

    eoc_on = '{3, 7, 11, 15};
    run_case(4'b1111, 0, -1);
    eoc_on = '{0, 0, 0, 0};
    run_case(4'b0101, 0, -1);
    eoc_on = '{3, 7, 11, 1000};
    run_case(4'b1111, 50, -1);
    eoc_on = '{3, 7, 11, 30};
    run_case(4'b1111, 30, -1);
    eoc_on = '{2, 5, 9, 1};
    run_case(4'b0000, 20, -1);
    run_case(4'b0011, 0, -1);

    eoc_on = '{1000, 1000, 1000, 1000};
    run_case(4'b1111, 0, 20);
    eoc_i  = '1;
    rst_ni = 1'b0;
    step();
    check_idle("midrun_rst");
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_idle("post_rst");
    end

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < N; i++) eoc_on[i] = int'($urandom_range(0, 70));
      run_case(N'($urandom), ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(5, 80), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/floo_cluster_sched.md
# floo_cluster_sched

Simulation-side run controller for the compute-tile array of the chiplet NoC. It releases compute clusters in a staggered order and collects their sticky end-of-computation flags. It enforces a cycle timeout, then runs a fixed drain period before it reports completion. It sits beside the DUT in the chiplet testbench and replaces the ad-hoc AND of cluster end-of-sim flags with a sequenced, observable controller.

## Interface
- NumClusters, 32, number of compute clusters sequenced
- StaggerCycles, 4, cycles between consecutive cluster releases (≥1)
- DrainCycles, 100, cycles waited after last completion before done
- CntWidth, 32, width of cycle counter and timeout
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, synchronous, active-low
- start_i  in  1  begin a run; sampled only in IDLE
- clear_i  in  1  return from DONE/TIMEOUT to IDLE
- enable_i  in  NumClusters  clusters taking part in the run; sampled at start
- timeout_i  in  CntWidth  cycle budget from start; 0 disables timeout
- eoc_i  in  NumClusters  per-cluster end-of-computation level
- fetch_en_o  out  NumClusters  per-cluster release; sticky until clear/reset
- busy_o  out  1  high in RELEASE, RUN, DRAIN
- done_o  out  1  high in DONE or TIMEOUT
- timeout_o  out  1  high in TIMEOUT
- done_mask_o  out  NumClusters  sticky captured completions
- num_done_o  out  $clog2(NumClusters+1)  popcount of done_mask_o
- cycles_o  out  CntWidth  cycles since start; frozen at done

## Operation
- States: IDLE, RELEASE, RUN, DRAIN, DONE, TIMEOUT.
- IDLE:
  - On start_i, latch enable_i into en_q and clear the counters and masks.
  - If en_q would be all zero, go to DRAIN. Otherwise go to RELEASE with ptr set to the lowest enabled index.
- RELEASE:
  - Set fetch_en_o[ptr].
  - Wait StaggerCycles cycles, then advance ptr to the next higher enabled index. Disabled indices cost no cycles.
  - After releasing the highest enabled index, go to RUN.
- Completion capture is active in RELEASE and RUN. done_mask[i] is set when eoc_i[i] & fetch_en_o[i] & en_q[i]. A cluster's eoc_i is ignored before that cluster is released; disabled clusters are ignored entirely.
- RUN: when (done_mask & en_q) == en_q, go to DRAIN.
- DRAIN: count DrainCycles cycles, then go to DONE.
- Timeout:
  - In RELEASE or RUN, if timeout_i != 0 and cycles == timeout_i - 1, go to TIMEOUT.
  - Completion in the same cycle takes priority: go to DRAIN, not TIMEOUT.
- DONE / TIMEOUT: hold all outputs. clear_i goes to IDLE and clears fetch_en_o, done_mask_o and cycles_o. start_i is ignored in these states.
- cycles_o:
  - Counts every cycle in RELEASE, RUN and DRAIN.
  - Saturates at all-ones and does not wrap.
  - Freezes on entry to DONE or TIMEOUT.
- Reset mid-run: all state returns to IDLE at the next edge and fetch_en_o drops. No partial results are kept.

## Timing
- Reset values:
  - state IDLE.
  - fetch_en_o, done_mask_o, num_done_o, cycles_o all 0.
  - busy_o, done_o, timeout_o all 0.
- All outputs are registered; there is no combinational input-to-output path.
- Releases:
  - Start sampled at edge t: first fetch_en_o bit high after edge t+1.
  - The k-th enabled cluster is released after edge t+1+k·StaggerCycles.
- A completion captured at edge e is visible on done_mask_o after e.
- The last completion at edge e gives DRAIN from e+1 and done_o after e+1+DrainCycles.
- With all-zero enable_i, done_o rises after edge t+1+DrainCycles.
- num_done_o is registered alongside done_mask_o, with the same latency.

## Structure
- Shared package floo_sched_pkg holds:
  - the state enum sched_state_e;
  - the default constants for StaggerCycles and DrainCycles.
- One sub-module, floo_sched_find_next: combinational next-set-bit finder above ptr over en_q, with a valid flag.
- Counters, FSM and capture logic live in the top module.

## Test plan
- NumClusters=4, enable=4'b1111, StaggerCycles=4, eoc pulses on all four after release:
  - fetch_en bits rise at t+1, t+5, t+9, t+13.
  - done_o rises DrainCycles+1 cycles after the last eoc.
  - timeout_o=0, num_done_o=4.
- enable=4'b0101, eoc_i held at 4'b1111 from reset:
  - only bits 0 and 2 are released, 4 cycles apart.
  - done_mask_o=4'b0101; bits 1 and 3 never set.
- timeout_i=50, cluster 3 never asserts eoc:
  - TIMEOUT entered with cycles_o=50.
  - done_o=1, timeout_o=1, done_mask_o=4'b0111, num_done_o=3.
- Last eoc arrives in the same cycle the timeout expires:
  - goes to DRAIN, then DONE; timeout_o stays 0.
- enable=0:
  - no fetch_en bit ever rises; done_o after DrainCycles+1 cycles.
  - clear_i returns to IDLE; a second start runs cleanly.
- rst_ni low for one cycle during RUN:
  - all outputs return to their reset values at the next edge.
  - eoc_i is ignored until the next start_i.
